// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO.
// Used by fifo_param and fifo_ptr_ctrl.
package fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_AF_THRESH = DEF_DEPTH - 1;

  // Ceiling log2, for sizing pointers and the occupancy counter.
  // Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and occupancy bookkeeping for fifo_param.
// Takes the already-accepted write/read strobes. It tracks the circular-buffer
// pointers and the entry count. Because DEPTH is a power of two, the pointers
// wrap from DEPTH-1 to 0 by natural binary overflow.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          i_wr_acc,
  input  logic          i_rd_acc,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Advance the pointers on accepted strobes. The count moves only when
  // exactly one side is active.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_wr_acc, i_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

endmodule : fifo_ptr_ctrl

// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with a registered read port.
// This block holds the storage array, the read data register and the status
// flags. fifo_ptr_ctrl handles the pointer and count updates.
// There is no fall-through: a read on an empty FIFO is rejected even when a
// write arrives in the same cycle.
// Optional feature: define FIFO_PARAM_ERR_EN to add the sticky ovf/udf flags.
module fifo_param
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int AF_THRESH = DEPTH - 1,
  localparam int PW        = clog2(DEPTH),
  localparam int CW        = clog2(DEPTH + 1)
) (
  input  logic             pclk,
  input  logic             clear,
  input  logic             en,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] wordIn,
  output logic [WIDTH-1:0] wordOut,
  output logic             rvalid,
  output logic [CW-1:0]    count,
  output logic             nempty,
  output logic             intr,
`ifdef FIFO_PARAM_ERR_EN
  output logic             ovf,
  output logic             udf,
`endif
  output logic             afull
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_word_out;
  logic             r_rvalid;

  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;
  logic [CW-1:0]    w_count;
  logic             w_rd_acc;
  logic             w_wr_acc;

  // A read needs data present. A write needs a free slot, or needs the slot
  // that a same-cycle read frees.
  assign w_rd_acc = en & read & (w_count != '0);
  assign w_wr_acc = en & write & ((w_count < FULL_CNT) | w_rd_acc);

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk      (pclk),
    .srst     (clear),
    .i_wr_acc (w_wr_acc),
    .i_rd_acc (w_rd_acc),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count)
  );

  // Storage write port. The storage is not reset. After a clear, old entries
  // are unreachable because the pointers and the count are zeroed.
  always_ff @(posedge pclk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_ptr] <= wordIn;
    end
  end

  // Registered read port. When full, a simultaneous read and write use the
  // same slot; the read returns the old word.
  always_ff @(posedge pclk) begin
    if (clear) begin
      r_word_out <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_word_out <= r_mem[w_rd_ptr];
      end
    end
  end

`ifdef FIFO_PARAM_ERR_EN
  logic r_ovf;
  logic r_udf;

  // Sticky error flags. A rejected request sets its flag; only clear resets it.
  always_ff @(posedge pclk) begin
    if (clear) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (en & write & ~w_wr_acc) begin
        r_ovf <= 1'b1;
      end
      if (en & read & ~w_rd_acc) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
`endif

  assign wordOut = r_word_out;
  assign rvalid  = r_rvalid;
  assign count   = w_count;
  // The status flags depend only on the count register, never on the requests.
  assign nempty  = (w_count != '0);
  assign intr    = (w_count == FULL_CNT);
  assign afull   = (w_count >= AF_CNT);

endmodule : fifo_param

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1 to 64.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, a power of two, legal range 2 to 256.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-1: almost-full level, legal range 1 to DEPTH.
REQ-004 SHALL have `pclk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have `clear`, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have `en`, input, 1 bit: active-high enable; when low, read and write are ignored.
REQ-007 SHALL have `write`, input, 1 bit: write request.
REQ-008 SHALL have `read`, input, 1 bit: read request.
REQ-009 SHALL have `wordIn`, input, WIDTH bits: write data.
REQ-010 SHALL have `wordOut`, output, WIDTH bits: registered read data.
REQ-011 SHALL have `rvalid`, output, 1 bit: `wordOut` was loaded by the read accepted in the previous cycle.
REQ-012 SHALL have `count`, output, clog2(DEPTH+1) bits: current occupancy.
REQ-013 SHALL have `nempty`, output, 1 bit: high when count is greater than 0.
REQ-014 SHALL have `intr`, output, 1 bit: high when count equals DEPTH (full).
REQ-015 SHALL have `afull`, output, 1 bit: high when count is greater than or equal to AF_THRESH.

Function
REQ-016 SHALL store entries in a circular buffer indexed by wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrapping from DEPTH-1 to 0 with no gap.
REQ-017 SHALL accept a write only when en=1, write=1 and (count<DEPTH or a read is accepted in the same cycle); an accepted write stores wordIn at wr_ptr and increments wr_ptr.
REQ-018 SHALL accept a read only when en=1, read=1 and count>0; an accepted read loads mem[rd_ptr] into wordOut at the same edge, increments rd_ptr, and sets rvalid high for exactly the following cycle.
REQ-019 SHALL, for read+write when empty, accept the write only; the read is rejected, rvalid stays 0 and count becomes 1 (no fall-through).
REQ-020 SHALL, for read+write when full, accept both; count stays DEPTH and the written word lands in the freed slot.
REQ-021 SHALL, for read+write with 0<count<DEPTH, accept both and leave count unchanged.
REQ-022 SHALL hold wordOut at its last loaded value when no read is accepted; wordOut is never high-impedance.
REQ-023 SHALL drive nempty, intr and afull combinationally from the count register only, with no path from the request inputs.
REQ-024 SHALL silently drop a rejected write (write when full without a read) and a rejected read (read when empty), with no state change.

Reset
REQ-025 SHALL, on a rising pclk edge with clear=1, set wr_ptr, rd_ptr and count to 0, wordOut to 0 and rvalid to 0, overriding en, read and write in that cycle.
REQ-026 SHALL, after clear is asserted mid-operation, discard all stored data; memory contents are not cleared but are unreachable.

Configuration
REQ-027 SHALL, with FIFO_PARAM_ERR_EN defined, add outputs `ovf` and `udf`, each 1 bit: sticky flags set by a rejected write and a rejected read respectively, cleared only by clear.
REQ-028 SHALL, without FIFO_PARAM_ERR_EN defined, omit ovf, udf and their logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL place the clog2 function and the default WIDTH, DEPTH and AF_THRESH constants in shared package fifo_pkg.
REQ-030 SHALL isolate pointer and count update logic in a sub-module fifo_ptr_ctrl (inputs: accepted write/read strobes; outputs: wr_ptr, rd_ptr, count); storage and the data path stay in fifo_param.

Verification
REQ-031 SHALL verify fill and drain (DEPTH=4, WIDTH=8): write 0x11,0x22,0x33,0x44, then read 4 times -> intr=1 after the 4th write; wordOut=0x11,0x22,0x33,0x44, each with rvalid one cycle after its read; nempty=0 at the end.
REQ-032 SHALL verify wrap-around (DEPTH=4): 6 writes interleaved with 6 reads (pointers wrap) -> data returned in order, count never exceeds 4.
REQ-033 SHALL verify simultaneous read+write (DEPTH=4): when full, write 0x55 with a read -> oldest word out, count stays 4, 0x55 read last; when empty, the same request -> count=1, rvalid=0.
REQ-034 SHALL verify reject and error flags (DEPTH=4): 5th write while full -> count stays 4, ovf=1 if FIFO_PARAM_ERR_EN; read when empty -> udf=1; both hold until clear.
REQ-035 SHALL verify reset mid-operation and en: clear=1 with count=3 while read=1 -> next cycle count=0, nempty=0, wordOut=0, rvalid=0; en=0 with write=1 -> count unchanged.
REQ-036 SHALL verify afull (DEPTH=8, AF_THRESH=6): afull asserts on the 6th write and deasserts after the first read.
